uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receiver for the RS232 datapath. It oversamples the serial line and supports configurable data width, optional parity and one or two stop bits. Received words go out through a valid/ready handshake, flagged with framing, parity and overrun errors. It is the next-generation replacement for the fixed 8N1 receiver; the downstream consumer is a FIFO or register interface.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..8.
- OVERSAMPLE, 16: sys_clk cycles per bit cell, even, legal 4..64.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- STOP_BITS, 1: stop bits checked, legal 1 or 2.

Ports:
- sys_clk  in  1  clock; all state changes on the rising edge.
- sys_rst_l  in  1  reset, asynchronous, active-low.
- uart_dataH  in  1  asynchronous serial line, idle high.
- rx_dataH  out  DATA_BITS  received word, LSB = first bit on the line.
- rx_validH  out  1  rx_dataH and the error flags hold a word.
- rx_readyH  in  1  consumer accepts the word on an edge where rx_validH=1.
- frame_errH  out  1  a sampled stop bit was 0; qualified by rx_validH.
- parity_errH  out  1  parity mismatch; qualified by rx_validH.
- overrunH  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- Input synchroniser: two flops, both reset to 1. All logic uses the second flop output (rxd).
- A bit-cell counter of width clog2(OVERSAMPLE) clears on every state entry and increments every cycle otherwise. A bit counter clears on entry to START and increments per sampled data bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rxd=0 -> START.
- START: at cnt=OVERSAMPLE/2-1, rxd=1 means a glitch -> IDLE, with no output and no flag. rxd=0 -> DATA.
- DATA: at cnt=OVERSAMPLE-1, shift rxd in LSB-first. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: at cnt=OVERSAMPLE-1, parity_err = XOR(data, rxd) != PARITY_ODD -> STOP.
- STOP: sample at cnt=OVERSAMPLE-1, STOP_BITS times. Any 0 sets the frame error. After the last sample, deliver the word. Go to BREAK if the last stop sample was 0, else IDLE.
- BREAK: stay until rxd=1, then IDLE. This prevents a held-low line from retriggering frames.
- Delivery: if rx_validH=0, or rx_readyH=1 on the same edge, load rx_dataH, frame_errH and parity_errH and hold rx_validH=1.
- Otherwise the new word is discarded, overrunH pulses for one cycle, and the old word and flags stay unchanged.
- Frames with errors are still delivered, with their flags set.
- rx_validH clears on an edge with rx_readyH=1, unless a new word loads on that same edge. While rx_validH=1, rx_dataH and the flags are stable.

## Timing
- Reset values:
  - state IDLE, counters 0, synchroniser 1;
  - rx_dataH 0, rx_validH 0, frame_errH 0, parity_errH 0, overrunH 0.
- Assertion of sys_rst_l mid-frame aborts the frame immediately. The first frame after release needs a fresh start edge.
- Detection latency: START is entered on edge E0, 3 edges after uart_dataH falls (2 synchroniser edges plus 1 state edge).
- Sample points:
  - START at E0+OVERSAMPLE/2;
  - each following bit OVERSAMPLE cycles later.
- rx_validH rises at E0 + OVERSAMPLE/2 + OVERSAMPLE·(DATA_BITS+PARITY_EN+STOP_BITS) + 1. For defaults this is E0+153.
- The FSM returns to IDLE during the second half of the last stop bit. Back-to-back frames with no idle time are received without loss.
- overrunH asserts on the delivery edge and deasserts on the next edge.
- No combinational path from rx_readyH to any output.

## Test plan
- Defaults, line 0x55 then 0xA3 back-to-back at 16 clk/bit, rx_readyH=1 -> two words 0x55, 0xA3 with flags 0; first rx_validH exactly 156 clocks after the line falling edge.
- PARITY_EN=1, PARITY_ODD=0, DATA_BITS=7, send 0x41 with parity 0 then with parity 1 -> rx_dataH=0x41 both times; parity_errH 0 then 1.
- STOP_BITS=2, second stop bit driven 0 on 0x3C -> rx_dataH=0x3C, frame_errH=1. Line held low 100 bit times, then high, then 0x12 -> exactly one more word, 0x12, with no error.
- 3-cycle low glitch on the idle line -> no rx_validH, no flags, FSM back in IDLE.
- rx_readyH=0, send 0x11 then 0x22 -> rx_dataH stays 0x11 and overrunH pulses once. Raise rx_readyH -> rx_validH drops the next edge.
- Assert sys_rst_l low at the DATA bit 4 sample of 0xFF, release, send 0x0F -> all outputs 0 during reset; next word 0x0F, no partial word.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: configurable data width, optional parity,
// one or two stop bits, valid/ready output with framing, parity and overrun flags.
module uart_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_l,
  input  logic                 uart_dataH,
  output logic [DATA_BITS-1:0] rx_dataH,
  output logic                 rx_validH,
  input  logic                 rx_readyH,
  output logic                 frame_errH,
  output logic                 parity_errH,
  output logic                 overrunH
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);
  localparam logic ParOdd = (PARITY_ODD != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} stateT;

  stateT                stateQ, stateD;
  logic                 rxMeta, rxd;
  logic [CntW-1:0]      cntQ, cntD;
  logic [BitW-1:0]      bitCntQ;
  logic [DATA_BITS-1:0] shiftQ;
  logic                 frameAccQ, parityAccQ, stop2Q, deliverQ;
  logic                 sampleTick, lastStop;

  assign sampleTick = (cntQ == CntLast);
  assign lastStop   = (STOP_BITS == 1) || stop2Q;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:   if (!rxd) stateD = StStart;
      StStart:  if (cntQ == CntHalf) stateD = rxd ? StIdle : StData;
      StData:   if (sampleTick && (bitCntQ == BitLast)) begin
        stateD = (PARITY_EN != 0) ? StParity : StStop;
      end
      StParity: if (sampleTick) stateD = StStop;
      // A low final stop sample parks in StBreak so a held-low line cannot retrigger.
      StStop:   if (sampleTick && lastStop) stateD = rxd ? StIdle : StBreak;
      StBreak:  if (rxd) stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  always_comb begin
    cntD = cntQ + CntW'(1);
    if (stateD != stateQ || sampleTick) cntD = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rxMeta <= 1'b1;
      rxd    <= 1'b1;
      stateQ <= StIdle;
      cntQ   <= '0;
    end else begin
      rxMeta <= uart_dataH;
      rxd    <= rxMeta;
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      bitCntQ    <= '0;
      shiftQ     <= '0;
      frameAccQ  <= 1'b0;
      parityAccQ <= 1'b0;
      stop2Q     <= 1'b0;
      deliverQ   <= 1'b0;
    end else begin
      if (stateD == StStart && stateQ != StStart) begin
        bitCntQ    <= '0;
        frameAccQ  <= 1'b0;
        parityAccQ <= 1'b0;
        stop2Q     <= 1'b0;
      end
      if (stateQ == StData && sampleTick) begin
        shiftQ  <= {rxd, shiftQ[DATA_BITS-1:1]};
        bitCntQ <= bitCntQ + BitW'(1);
      end
      if (stateQ == StParity && sampleTick) begin
        parityAccQ <= ((^shiftQ) ^ rxd) != ParOdd;
      end
      if (stateQ == StStop && sampleTick) begin
        if (!rxd) frameAccQ <= 1'b1;
        stop2Q <= 1'b1;
      end
      // Delivery happens one edge after the final stop sample so its flag is included.
      deliverQ <= (stateQ == StStop) && sampleTick && lastStop;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rx_dataH    <= '0;
      rx_validH   <= 1'b0;
      frame_errH  <= 1'b0;
      parity_errH <= 1'b0;
      overrunH    <= 1'b0;
    end else begin
      overrunH <= 1'b0;
      if (deliverQ && (!rx_validH || rx_readyH)) begin
        rx_dataH    <= shiftQ;
        frame_errH  <= frameAccQ;
        parity_errH <= parityAccQ;
        rx_validH   <= 1'b1;
      end else begin
        if (deliverQ) overrunH <= 1'b1;
        if (rx_readyH) rx_validH <= 1'b0;
      end
    end
  end

endmodule
